// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite types and encodings for the ahb_lite_master initiator.
// stage_t is sized by AHB_ADDR_W/AHB_DATA_W; change them here for a 64-bit data bus.
package ahb_lite_pkg;

  localparam int AHB_ADDR_W = 16;
  localparam int AHB_DATA_W = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef struct packed {
    logic                  valid;
    logic                  write;
    logic [AHB_ADDR_W-1:0] addr;
    logic [2:0]            size;
    logic [AHB_DATA_W-1:0] wdata;
  } stage_t;

  function automatic logic [2:0] sat_size(input logic [2:0] size, input logic [2:0] max_size);
    return (size > max_size) ? max_size : size;
  endfunction

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: valid/ready commands -> pipelined SINGLE NONSEQ transfers, one response each.
// Optional error statistics (err_count/err_addr/err_clr) with AHB_LITE_MASTER_ERR_STAT_EN.
module ahb_lite_master
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_W   = AHB_ADDR_W,
  parameter int DATA_W   = AHB_DATA_W,
  parameter int MAX_SIZE = $clog2(DATA_W/8)
) (
  input  logic              HCLK,
  input  logic              HRESETn,
`ifdef AHB_LITE_MASTER_ERR_STAT_EN
  input  logic              err_clr,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] err_addr,
`endif
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [1:0]        HTRANS,
  output logic [DATA_W-1:0] HWDATA,
  output logic              HSEL,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  localparam logic [2:0] MAX_SIZE_L = 3'(MAX_SIZE);

  stage_t              a_q, a_d;
  logic                d_valid_q, d_valid_d;
  logic                d_write_q, d_write_d;
  logic [DATA_W-1:0]   d_wdata_q, d_wdata_d;

  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q,   rsp_err_d;

  logic                d_done;

  assign d_done    = HREADY && d_valid_q;
  assign cmd_ready = HREADY;

  // An idle A stage keeps its address/control so the bus does not toggle needlessly.
  always_comb begin
    a_d       = a_q;
    d_valid_d = d_valid_q;
    d_write_d = d_write_q;
    d_wdata_d = d_wdata_q;
    if (HREADY) begin
      d_valid_d = a_q.valid;
      d_write_d = a_q.write;
      d_wdata_d = a_q.wdata;
      a_d.valid = 1'b0;
      if (cmd_valid) begin
        a_d.valid = 1'b1;
        a_d.write = cmd_write;
        a_d.addr  = cmd_addr;
        a_d.size  = sat_size(cmd_size, MAX_SIZE_L);
        a_d.wdata = cmd_wdata;
      end
    end
  end

  always_comb begin
    rsp_valid_d = d_done;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (d_done) begin
      rsp_write_d = d_write_q;
      rsp_rdata_d = d_write_q ? '0 : HRDATA;
      rsp_err_d   = (HRESP == HRESP_ERROR);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_q         <= '0;
      d_valid_q   <= 1'b0;
      d_write_q   <= 1'b0;
      d_wdata_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      a_q         <= a_d;
      d_valid_q   <= d_valid_d;
      d_write_q   <= d_write_d;
      d_wdata_q   <= d_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign HADDR     = a_q.addr;
  assign HWRITE    = a_q.write;
  assign HSIZE     = a_q.size;
  assign HBURST    = HBURST_SINGLE;
  assign HTRANS    = a_q.valid ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HSEL      = HTRANS[1];
  assign HWDATA    = d_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

`ifdef AHB_LITE_MASTER_ERR_STAT_EN
  // The address follows the transfer A -> D -> response so err_addr names the failing beat.
  logic [ADDR_W-1:0] d_addr_q, rsp_addr_q;
  logic [15:0]       err_count_q;
  logic [ADDR_W-1:0] err_addr_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      d_addr_q    <= '0;
      rsp_addr_q  <= '0;
      err_count_q <= '0;
      err_addr_q  <= '0;
    end else begin
      if (HREADY) d_addr_q <= a_q.addr;
      if (d_done) rsp_addr_q <= d_addr_q;
      if (err_clr) begin
        err_count_q <= '0;
        err_addr_q  <= '0;
      end else if (rsp_valid_q && rsp_err_q) begin
        if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
        err_addr_q <= rsp_addr_q;
      end
    end
  end

  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;
`endif

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master with a small word-addressed memory slave.
// Build with AHB_LITE_MASTER_ERR_STAT_EN to also exercise the error statistics.
module tb_ahb_lite_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_write, rsp_err;
  logic [31:0] rsp_rdata;
  logic [15:0] HADDR;
  logic        HWRITE, HSEL, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA, HRDATA;
`ifdef AHB_LITE_MASTER_ERR_STAT_EN
  logic        err_clr;
  logic [15:0] err_count;
  logic [15:0] err_addr;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_master dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
`ifdef AHB_LITE_MASTER_ERR_STAT_EN
    .err_clr(err_clr), .err_count(err_count), .err_addr(err_addr),
`endif
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS),
    .HWDATA(HWDATA), .HSEL(HSEL), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  // memory slave; HREADY/HRESP are driven directly by the test tasks
  logic [31:0] mem [0:63];
  logic        dph_valid, dph_write;
  logic [5:0]  dph_idx;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dph_valid <= 1'b0;
      dph_write <= 1'b0;
      dph_idx   <= '0;
    end else if (HREADY) begin
      if (dph_valid && dph_write) mem[dph_idx] <= HWDATA;
      dph_valid <= HTRANS[1];
      dph_write <= HWRITE;
      dph_idx   <= HADDR[7:2];
    end
  end

  assign HRDATA = (dph_valid && !dph_write) ? mem[dph_idx] : 32'h0;

  always @(posedge HCLK) cyc <= cyc + 1;

  int          rq_cyc [$];
  logic [31:0] rq_data [$];
  logic        rq_err [$];
  logic        rq_wr [$];

  always @(negedge HCLK) begin
    if (HRESETn === 1'b1 && rsp_valid === 1'b1) begin
      rq_cyc.push_back(cyc);
      rq_data.push_back(rsp_rdata);
      rq_err.push_back(rsp_err);
      rq_wr.push_back(rsp_write);
    end
  end

  task automatic tick();
    @(negedge HCLK);
    #1;
  endtask

  task automatic clear_rsp();
    rq_cyc.delete(); rq_data.delete(); rq_err.delete(); rq_wr.delete();
  endtask

  task automatic send(input logic w, input logic [15:0] a, input logic [2:0] s,
                      input logic [31:0] d, output int acc);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d;
    tick();
    acc = cyc;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_size = '0; cmd_wdata = '0; HREADY = 1'b1; HRESP = 1'b0;
`ifdef AHB_LITE_MASTER_ERR_STAT_EN
    err_clr = 1'b0;
`endif
    tick(); tick();
    n_checks++; if (HTRANS !== 2'b00) begin n_fail++; $display("FAIL reset_htrans got %b want 00", HTRANS); end
    n_checks++; if (HSEL !== 1'b0) begin n_fail++; $display("FAIL reset_hsel got %b want 0", HSEL); end
    n_checks++; if (HADDR !== 16'h0) begin n_fail++; $display("FAIL reset_haddr got %h want 0", HADDR); end
    n_checks++; if (HWRITE !== 1'b0) begin n_fail++; $display("FAIL reset_hwrite got %b want 0", HWRITE); end
    n_checks++; if (HSIZE !== 3'b0) begin n_fail++; $display("FAIL reset_hsize got %b want 000", HSIZE); end
    n_checks++; if (HBURST !== 3'b0) begin n_fail++; $display("FAIL reset_hburst got %b want 000", HBURST); end
    n_checks++; if (HWDATA !== 32'h0) begin n_fail++; $display("FAIL reset_hwdata got %h want 0", HWDATA); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_checks++; if (rsp_write !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rsp_fields got w=%b e=%b d=%h want 0/0/0", rsp_write, rsp_err, rsp_rdata); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
`ifdef AHB_LITE_MASTER_ERR_STAT_EN
    n_checks++; if (err_count !== 16'h0 || err_addr !== 16'h0) begin
      n_fail++; $display("FAIL reset_err_stat got cnt=%h addr=%h want 0/0", err_count, err_addr); end
`endif
    HRESETn = 1'b1;
    tick();
  endtask

  // zero-wait write then read; the response arrives two edges after the accept edge
  task automatic test_zero_wait();
    int acc0, acc1;
    clear_rsp();
    send(1'b1, 16'h0010, 3'd2, 32'hDEADBEEF, acc0);
    cmd_valid = 1'b0;
    n_checks++; if (HTRANS !== 2'b10 || HADDR !== 16'h0010 || HWRITE !== 1'b1 || HSEL !== 1'b1) begin
      n_fail++; $display("FAIL zw_wr_addr_phase got trans=%b addr=%h wr=%b sel=%b want 10/0010/1/1", HTRANS, HADDR, HWRITE, HSEL); end
    tick();
    n_checks++; if (HTRANS !== 2'b00) begin n_fail++; $display("FAIL zw_single_nonseq got %b want 00", HTRANS); end
    n_checks++; if (HWDATA !== 32'hDEADBEEF) begin n_fail++; $display("FAIL zw_hwdata got %h want deadbeef", HWDATA); end
    send(1'b0, 16'h0010, 3'd2, 32'h0, acc1);
    cmd_valid = 1'b0;
    n_checks++; if (HTRANS !== 2'b10 || HWRITE !== 1'b0) begin
      n_fail++; $display("FAIL zw_rd_addr_phase got trans=%b wr=%b want 10/0", HTRANS, HWRITE); end
    repeat (4) tick();
    n_checks++;
    if (rq_cyc.size() !== 2) begin
      n_fail++; $display("FAIL zw_rsp_count got %0d want 2", rq_cyc.size());
    end else begin
      n_checks++; if (rq_cyc[0] !== acc0 + 2 || rq_wr[0] !== 1'b1 || rq_data[0] !== 32'h0 || rq_err[0] !== 1'b0) begin
        n_fail++; $display("FAIL zw_wr_rsp got cyc=%0d w=%b d=%h e=%b want cyc=%0d w=1 d=0 e=0", rq_cyc[0], rq_wr[0], rq_data[0], rq_err[0], acc0 + 2); end
      n_checks++; if (rq_cyc[1] !== acc1 + 2 || rq_wr[1] !== 1'b0 || rq_data[1] !== 32'hDEADBEEF || rq_err[1] !== 1'b0) begin
        n_fail++; $display("FAIL zw_rd_rsp got cyc=%0d w=%b d=%h e=%b want cyc=%0d w=0 d=deadbeef e=0", rq_cyc[1], rq_wr[1], rq_data[1], rq_err[1], acc1 + 2); end
    end
  endtask

  task automatic test_back_to_back();
    int acc [4];
    logic [31:0] wd [4];
    clear_rsp();
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'h1111_0000 + 32'(i);
      send(1'b1, 16'(4 * i), 3'd2, wd[i], acc[i]);
      n_checks++; if (HTRANS !== 2'b10 || HADDR !== 16'(4 * i)) begin
        n_fail++; $display("FAIL b2b_addr[%0d] got trans=%b addr=%h want 10/%h", i, HTRANS, HADDR, 16'(4 * i)); end
      if (i > 0) begin
        n_checks++; if (HWDATA !== wd[i-1]) begin
          n_fail++; $display("FAIL b2b_hwdata[%0d] got %h want %h", i, HWDATA, wd[i-1]); end
      end
    end
    cmd_valid = 1'b0;
    tick();
    n_checks++; if (HWDATA !== wd[3] || HTRANS !== 2'b00) begin
      n_fail++; $display("FAIL b2b_last_data got d=%h trans=%b want %h/00", HWDATA, HTRANS, wd[3]); end
    repeat (3) tick();
    n_checks++;
    if (rq_cyc.size() !== 4) begin
      n_fail++; $display("FAIL b2b_rsp_count got %0d want 4", rq_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (rq_cyc[i] !== acc[0] + 2 + i || rq_wr[i] !== 1'b1) begin
          n_fail++; $display("FAIL b2b_rsp[%0d] got cyc=%0d w=%b want cyc=%0d w=1", i, rq_cyc[i], rq_wr[i], acc[0] + 2 + i); end
      end
    end
  endtask

  task automatic test_wait_states();
    int acc, dummy;
    logic [31:0] hwd;
    send(1'b1, 16'h0020, 3'd2, 32'hCAFE0020, dummy);
    cmd_valid = 1'b0;
    repeat (3) tick();
    clear_rsp();
    send(1'b0, 16'h0020, 3'd2, 32'h0, acc);
    cmd_valid = 1'b0;
    tick();
    HREADY = 1'b0;
    hwd = HWDATA;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ws_cmd_ready[%0d] got %b want 0", i, cmd_ready); end
      tick();
      n_checks++; if (HTRANS !== 2'b00 || HADDR !== 16'h0020 || HWDATA !== hwd) begin
        n_fail++; $display("FAIL ws_hold[%0d] got trans=%b addr=%h d=%h want 00/0020/%h", i, HTRANS, HADDR, HWDATA, hwd); end
    end
    HREADY = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (rq_cyc.size() !== 1) begin
      n_fail++; $display("FAIL ws_rsp_count got %0d want 1", rq_cyc.size());
    end else begin
      n_checks++; if (rq_cyc[0] !== acc + 4 || rq_data[0] !== 32'hCAFE0020 || rq_err[0] !== 1'b0) begin
        n_fail++; $display("FAIL ws_rsp got cyc=%0d d=%h e=%b want cyc=%0d d=cafe0020 e=0", rq_cyc[0], rq_data[0], rq_err[0], acc + 4); end
    end
  endtask

  task automatic test_error();
    int acc_w, acc_r;
    clear_rsp();
    send(1'b1, 16'hFFFC, 3'd2, 32'hBAD0BAD0, acc_w);
    send(1'b0, 16'h0004, 3'd2, 32'h0, acc_r);
    cmd_valid = 1'b0;
    HREADY = 1'b0; HRESP = 1'b1;
    tick();
    n_checks++; if (HTRANS !== 2'b10 || HADDR !== 16'h0004 || rq_cyc.size() !== 0) begin
      n_fail++; $display("FAIL err_first_cycle got trans=%b addr=%h rsps=%0d want 10/0004/0", HTRANS, HADDR, rq_cyc.size()); end
    HREADY = 1'b1;
    tick();
    HRESP = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (rq_cyc.size() !== 2) begin
      n_fail++; $display("FAIL err_rsp_count got %0d want 2", rq_cyc.size());
    end else begin
      n_checks++; if (rq_cyc[0] !== acc_w + 3 || rq_wr[0] !== 1'b1 || rq_err[0] !== 1'b1) begin
        n_fail++; $display("FAIL err_wr_rsp got cyc=%0d w=%b e=%b want cyc=%0d w=1 e=1", rq_cyc[0], rq_wr[0], rq_err[0], acc_w + 3); end
      n_checks++; if (rq_cyc[1] !== acc_r + 3 || rq_err[1] !== 1'b0 || rq_data[1] !== 32'h11110001) begin
        n_fail++; $display("FAIL err_rd_rsp got cyc=%0d e=%b d=%h want cyc=%0d e=0 d=11110001", rq_cyc[1], rq_err[1], rq_data[1], acc_r + 3); end
    end
`ifdef AHB_LITE_MASTER_ERR_STAT_EN
    n_checks++; if (err_count !== 16'd1 || err_addr !== 16'hFFFC) begin
      n_fail++; $display("FAIL err_stat got cnt=%h addr=%h want 0001/fffc", err_count, err_addr); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_checks++; if (err_count !== 16'd0 || err_addr !== 16'h0) begin
      n_fail++; $display("FAIL err_clr got cnt=%h addr=%h want 0/0", err_count, err_addr); end
`endif
  endtask

  task automatic test_reset_mid();
    int acc0, acc1;
    send(1'b0, 16'h0010, 3'd2, 32'h0, acc0);
    send(1'b0, 16'h0014, 3'd2, 32'h0, acc1);
    cmd_valid = 1'b0;
    HREADY = 1'b0;
    tick();
    n_checks++; if (HTRANS !== 2'b10 || HSEL !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre got trans=%b sel=%b want 10/1", HTRANS, HSEL); end
    clear_rsp();
    #2 HRESETn = 1'b0;
    #1;
    n_checks++; if (HTRANS !== 2'b00 || HSEL !== 1'b0 || HADDR !== 16'h0) begin
      n_fail++; $display("FAIL rst_async got trans=%b sel=%b addr=%h want 00/0/0", HTRANS, HSEL, HADDR); end
    tick(); tick();
    HRESETn = 1'b1; HREADY = 1'b1;
    repeat (4) tick();
    n_checks++; if (rq_cyc.size() !== 0) begin
      n_fail++; $display("FAIL rst_no_rsp got %0d responses want 0", rq_cyc.size()); end
  endtask

  task automatic test_size_sat();
    int acc;
    send(1'b0, 16'h0030, 3'b101, 32'h0, acc);
    n_checks++; if (HSIZE !== 3'b010) begin n_fail++; $display("FAIL size_sat_101 got %b want 010", HSIZE); end
    send(1'b0, 16'h0031, 3'b011, 32'h0, acc);
    n_checks++; if (HSIZE !== 3'b010) begin n_fail++; $display("FAIL size_sat_011 got %b want 010", HSIZE); end
    send(1'b0, 16'h0031, 3'b001, 32'h0, acc);
    n_checks++; if (HSIZE !== 3'b001 || HADDR !== 16'h0031) begin
      n_fail++; $display("FAIL size_half got size=%b addr=%h want 001/0031", HSIZE, HADDR); end
    cmd_valid = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_back_to_back();
    test_wait_states();
    test_error();
    test_reset_mid();
    test_size_sat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
- Synthesizable AHB-Lite initiator: the master end of the AHB-Lite bus whose slave end is the memory DUT.
- Converts a simple valid/ready command stream into pipelined single (HBURST=SINGLE) NONSEQ transfers.
- Returns one response per command, carrying read data and error status.
- Drives the same 16-bit address / 32-bit data bus as the existing bench, so it can replace the UVM master agent for RTL-level integration tests.

Parameters:
- ADDR_W, 16, HADDR width.
- DATA_W, 32, HWDATA/HRDATA width (32 or 64).
- MAX_SIZE, $clog2(DATA_W/8), largest legal HSIZE encoding.

Ports:
- HCLK  in  1  bus clock
- HRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when cmd_valid&&cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  byte address
- cmd_size  in  3  HSIZE encoding
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_write  out  1  direction of the completed transfer
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_err  out  1  slave returned ERROR
- HADDR  out  ADDR_W
- HWRITE  out  1
- HSIZE  out  3
- HBURST  out  3  constant 3'b000
- HTRANS  out  2  IDLE=00 or NONSEQ=10 only
- HWDATA  out  DATA_W
- HSEL  out  1  equals HTRANS[1] (single-slave system)
- HRDATA  in  DATA_W
- HREADY  in  1
- HRESP  in  1

Behaviour:
- Clock/reset: single clock HCLK; reset is asynchronous, active-low (HRESETn).
- Reset values: HTRANS=IDLE, HSEL=0, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HWDATA=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_err=0.
- Pipeline: two register stages, A (address phase) and D (data phase); all bus outputs are registered.
- cmd_ready = HREADY, a combinational path from input to output.
- Stall: while HREADY=0, the A and D stages and all bus outputs hold.
- Advance: on a posedge with HREADY=1:
  - D <= A, including HWDATA <= A.wdata.
  - A <= the accepted command if cmd_valid; otherwise A becomes IDLE with HADDR/HWRITE/HSIZE holding their previous values.
- Back-to-back commands produce one NONSEQ per cycle with no IDLE gap, as long as HREADY=1.
- Completion: a posedge with D valid and HREADY=1 completes the D transfer. On the next cycle:
  - rsp_valid=1
  - rsp_rdata = HRDATA sampled at that edge for reads, 0 for writes
  - rsp_err = HRESP sampled at that edge
- Latency: command accepted at edge N -> address phase cycle N+1 -> data phase N+2 (zero wait states) -> rsp_valid high in cycle N+3.
- Wait states: each HREADY=0 cycle adds one cycle of latency.
- ERROR response:
  - First cycle (HRESP=1, HREADY=0) is treated as a wait state.
  - Second cycle (HRESP=1, HREADY=1) completes the transfer with rsp_err=1.
  - An already-issued A-stage transfer is not cancelled; it proceeds normally, which is legal AHB-Lite.
- Size: cmd_size > MAX_SIZE is saturated to MAX_SIZE. No alignment check; HADDR passes through unchanged.
- Reset mid-transfer: all stages clear immediately and no response is produced for in-flight commands.
- HREADY=0 sampled while D is empty (slave anomaly): outputs hold; no response is produced.

Optional Feature:
- Macro: AHB_LITE_MASTER_ERR_STAT_EN.
- Defined:
  - Adds output err_count [15:0]: reset 0, increments once per rsp_err pulse, saturates at 16'hFFFF.
  - Adds output err_addr [ADDR_W-1:0]: HADDR of the most recent erroring transfer, captured through the pipeline; reset 0.
  - Adds input err_clr: synchronous, clears both outputs; err_clr wins over a same-cycle increment.
- Undefined: these ports and registers are absent; core behaviour is identical.

Decomposition:
- Shared package ahb_lite_pkg holds:
  - htrans_t: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11
  - hburst constant SINGLE=3'b000
  - hsize constants BYTE=0, HALF=1, WORD=2, DWORD=3
  - hresp constants OKAY=0, ERROR=1
  - stage struct {valid, write, addr, size, wdata}
- No sub-module; both pipeline stages live in one module.

Test Plan:
- Zero-wait write: write 0x0010 <- 0xDEADBEEF, then read 0x0010 against the memory slave -> one NONSEQ cycle each; read rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 3 cycles after each accept.
- Back-to-back: 4 writes to 0x0000/4/8/C, cmd_valid held high, HREADY=1 -> 4 consecutive NONSEQ cycles; HWDATA lags HADDR by exactly 1 cycle; 4 rsp_valid pulses on consecutive cycles.
- Wait states: slave inserts 2 HREADY=0 cycles on a read of 0x0020 -> HADDR/HTRANS/HWDATA stable throughout; cmd_ready=0 for 2 cycles; rsp_valid 5 cycles after accept.
- Error: slave returns two-cycle ERROR on a write to 0xFFFC -> rsp_err=1; the following pipelined read to 0x0004 still completes with rsp_err=0. With AHB_LITE_MASTER_ERR_STAT_EN: err_count=1, err_addr=0xFFFC.
- Reset mid-operation: assert HRESETn=0 during the data phase of a stalled read -> HTRANS=IDLE and HSEL=0 asynchronously; no rsp_valid after reset release.
- Size saturation: cmd_size=3'b101 with DATA_W=32 -> HSIZE=3'b010 on the bus.
